// File: rtl/vmx_pkg.sv
// Shared types and constants for the vector-MAC chain sequencer.
package vmx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } vmx_state_t;

    localparam logic [7:0] LOAD_FLAG  = 8'h80;
    localparam logic [7:0] LOAD_IDLE  = 8'h00;
    localparam int         MAX_NUM_PE = 64;

endpackage

// File: rtl/vmx_result_fifo.sv
// Synchronous result FIFO; the count output feeds the sequencer's credit logic.
module vmx_result_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && (count != FULL);
    assign do_rd   = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/vmx_chain_seq.sv
// Sequencer for a linear vector-MAC PE chain: weight preload, credited streaming, tail capture.
// Optional SIMD mode enabled by defining VMX_CHAIN_SEQ_SIMD_EN.
module vmx_chain_seq
    import vmx_pkg::*;
#(
    parameter int NUM_PE         = 8,
    parameter int VECTOR_BITLEN  = 16,
    parameter int PRODUCT_BITLEN = 32,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_load,
    input  logic                              cmd_simd,
    input  logic [15:0]                       cmd_len,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [VECTOR_BITLEN-1:0]          w_data,
    input  logic                              v_valid,
    output logic                              v_ready,
    input  logic [VECTOR_BITLEN-1:0]          v_data,
    output logic                              pe_simd_mode,
    output logic [7:0]                        pe_load_ctrl,
    output logic [VECTOR_BITLEN-1:0]          pe_data,
    output logic [PRODUCT_BITLEN-1:0]         pe_sum_in,
    input  logic [PRODUCT_BITLEN-1:0]         pe_sum_out,
    output logic                              r_valid,
    input  logic                              r_ready,
    output logic [PRODUCT_BITLEN-1:0]         r_data,
    output logic                              busy,
    output logic                              done,
    output vmx_state_t                        dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]       dbg_credits
);

    // Every handshake transfers a word on a rising edge where valid and ready are both high.
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [5:0]  LAST_PE = 6'(NUM_PE - 1);

    vmx_state_t         state;
    vmx_state_t         state_next;
    logic [15:0]        len_q;
    logic [15:0]        vec_cnt;
    logic [5:0]         load_idx;
    logic [NUM_PE-1:0]  tag_sr;
    logic               tag_exit;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      credits;
    logic [CW-1:0]      fifo_count;
    logic               cmd_fire;
    logic               w_fire;
    logic               v_fire;
    logic               pop;
    logic               pipe_empty;

    assign cmd_ready  = (state == ST_IDLE) && !rst;
    assign w_ready    = (state == ST_LOAD);
    assign v_ready    = (state == ST_STREAM) && (credits != '0);
    assign busy       = (state != ST_IDLE);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign w_fire     = w_valid && w_ready;
    assign v_fire     = v_valid && v_ready;
    assign pop        = r_valid && r_ready;
    assign pipe_empty = (tag_sr == '0) && !tag_exit;
    assign pe_sum_in  = '0;
    assign r_valid    = (fifo_count != '0);
    assign dbg_state  = state;
    assign dbg_credits = credits;

    // Tags still in the chain hold a FIFO slot in reserve, so the unstallable tail never overflows.
    assign credits = CW'(FIFO_DEPTH) - fifo_count - inflight;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_load)             state_next = ST_LOAD;
                    else if (cmd_len == '0)   state_next = ST_DRAIN;
                    else                      state_next = ST_STREAM;
                end
            end
            ST_LOAD: begin
                if (w_fire && (load_idx == LAST_PE))
                    state_next = (len_q == '0) ? ST_DRAIN : ST_STREAM;
            end
            ST_STREAM: begin
                if (v_fire && (vec_cnt == len_q - 16'd1)) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pipe_empty) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            vec_cnt      <= '0;
            load_idx     <= '0;
            tag_sr       <= '0;
            tag_exit     <= 1'b0;
            inflight     <= '0;
            pe_load_ctrl <= LOAD_IDLE;
            pe_data      <= '0;
            done         <= 1'b0;
        end else begin
            state    <= state_next;
            done     <= (state == ST_DRAIN) && pipe_empty;
            tag_sr   <= (tag_sr << 1) | NUM_PE'(v_fire);
            tag_exit <= tag_sr[NUM_PE-1];

            if (cmd_fire) begin
                len_q    <= cmd_len;
                vec_cnt  <= '0;
                load_idx <= '0;
            end
            if (w_fire) load_idx <= load_idx + 6'd1;
            if (v_fire) vec_cnt  <= vec_cnt + 16'd1;

            case ({v_fire, tag_exit})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            if (w_fire) begin
                pe_load_ctrl <= LOAD_FLAG | {2'b00, load_idx};
                pe_data      <= w_data;
            end else if (v_fire) begin
                pe_load_ctrl <= LOAD_IDLE;
                pe_data      <= v_data;
            end else begin
                pe_load_ctrl <= LOAD_IDLE;
                pe_data      <= '0;
            end
        end
    end

`ifdef VMX_CHAIN_SEQ_SIMD_EN
    logic simd_q;

    always_ff @(posedge clk) begin
        if (rst)           simd_q <= 1'b0;
        else if (cmd_fire) simd_q <= cmd_simd;
    end

    assign pe_simd_mode = simd_q;
`else
    logic unused_simd;

    assign unused_simd  = cmd_simd;
    assign pe_simd_mode = 1'b0;
`endif

    // The chain's tail sum is valid the cycle after its tag leaves the shift register.
    vmx_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PRODUCT_BITLEN)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tag_exit),
        .wr_data (pe_sum_out),
        .rd_en   (pop),
        .rd_data (r_data),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_vmx_chain_seq.sv
// Scoreboard bench for vmx_chain_seq with a behavioural PE-chain stand-in.
module tb_vmx_chain_seq;
    import vmx_pkg::*;

    localparam int NUM_PE = 4;
    localparam int VB     = 16;
    localparam int PB     = 32;
    localparam int FD     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_load, cmd_simd;
    logic [15:0]   cmd_len;
    logic          w_valid, w_ready;
    logic [VB-1:0] w_data;
    logic          v_valid, v_ready;
    logic [VB-1:0] v_data;
    logic          pe_simd_mode;
    logic [7:0]    pe_load_ctrl;
    logic [VB-1:0] pe_data;
    logic [PB-1:0] pe_sum_in, pe_sum_out;
    logic          r_valid, r_ready;
    logic [PB-1:0] r_data;
    logic          busy, done;
    vmx_state_t    dbg_state;
    logic [$clog2(FD):0] dbg_credits;

    vmx_chain_seq #(
        .NUM_PE(NUM_PE), .VECTOR_BITLEN(VB), .PRODUCT_BITLEN(PB), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_simd(cmd_simd), .cmd_len(cmd_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .v_valid(v_valid), .v_ready(v_ready), .v_data(v_data),
        .pe_simd_mode(pe_simd_mode), .pe_load_ctrl(pe_load_ctrl), .pe_data(pe_data),
        .pe_sum_in(pe_sum_in), .pe_sum_out(pe_sum_out),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .busy(busy), .done(done), .dbg_state(dbg_state), .dbg_credits(dbg_credits)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain stand-in: NUM_PE register stages, tail sum = 3*data + 1.
    logic [VB-1:0] chain [NUM_PE];
    always @(posedge clk) begin
        chain[0] <= pe_data;
        for (int i = 1; i < NUM_PE; i++) chain[i] <= chain[i-1];
    end
    assign pe_sum_out = 32'(chain[NUM_PE-1]) * 32'd3 + 32'd1;

    // ---------------- scoreboard ----------------
    logic [PB-1:0] exp_q[$];
    logic [23:0]   ld_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int done_cnt = 0;
    int rv_rise  = -1;
    int last_ld  = -10;
    logic rv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (r_valid && r_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL r_unexpected actual=%0h expected=none", r_data);
                end else begin
                    check("r_data", r_data, exp_q.pop_front());
                end
            end
            if (r_valid && !rv_prev) rv_rise = cyc;
            rv_prev = r_valid;
            if (done) done_cnt++;
            if (pe_load_ctrl != 8'h00) begin
                if (ld_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL load_unexpected actual=%0h expected=none", pe_load_ctrl);
                end else begin
                    check("load_ctrl_data", {pe_load_ctrl, pe_data}, ld_q.pop_front());
                end
                if (pe_load_ctrl[5:0] != 6'd0) check("load_consecutive", cyc, last_ld + 1);
                last_ld = cyc;
            end
        end else begin
            rv_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic ld, input logic sm, input logic [15:0] len);
        int n = 0;
        cmd_valid = 1'b1; cmd_load = ld; cmd_simd = sm; cmd_len = len;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        check("cmd_accept", cmd_ready, 1'b1);
        align();
        cmd_valid = 1'b0; cmd_load = 1'b0; cmd_simd = 1'b0; cmd_len = '0;
    endtask

    task automatic send_weight(input logic [VB-1:0] w, input logic [7:0] ctrl);
        int n = 0;
        w_valid = 1'b1; w_data = w;
        @(negedge clk);
        while (!w_ready && n < 200) begin @(negedge clk); n++; end
        check("w_accept", w_ready, 1'b1);
        if (w_ready) ld_q.push_back({ctrl, w});
        align();
        w_valid = 1'b0; w_data = '0;
    endtask

    task automatic send_vec(input logic [VB-1:0] v, input logic [PB-1:0] exp, output int acc_cyc);
        int n = 0;
        v_valid = 1'b1; v_data = v;
        @(negedge clk);
        while (!v_ready && n < 200) begin @(negedge clk); n++; end
        check("v_accept", v_ready, 1'b1);
        acc_cyc = cyc;
        if (v_ready) begin
            exp_q.push_back(exp);
            n_acc++;
        end
        align();
        v_valid = 1'b0; v_data = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin @(negedge clk); n++; end
        check("idle_reached", busy, 1'b0);
        repeat (3) @(negedge clk);
        align();
    endtask

    // ---------------- stimulus tables ----------------
    logic [VB-1:0] wts   [4]  = '{16'd1, 16'd2, 16'd3, 16'd4};
    logic [7:0]    wctl  [4]  = '{8'h80, 8'h81, 8'h82, 8'h83};
    logic [VB-1:0] vec_a [3]  = '{16'd10, 16'd20, 16'd30};
    logic [PB-1:0] exp_a [3]  = '{32'd31, 32'd61, 32'd91};
    logic [VB-1:0] vec_b [10] = '{16'd5, 16'd12, 16'd19, 16'd26, 16'd33,
                                  16'd40, 16'd47, 16'd54, 16'd61, 16'd68};
    logic [PB-1:0] exp_b [10] = '{32'd16, 32'd37, 32'd58, 32'd79, 32'd100,
                                  32'd121, 32'd142, 32'd163, 32'd184, 32'd205};
    logic [VB-1:0] vec_s [2]  = '{16'd258, 16'd772};
    logic [PB-1:0] exp_s [2]  = '{32'd775, 32'd2317};

`ifdef VMX_CHAIN_SEQ_SIMD_EN
    localparam logic SIMD_EXP = 1'b1;
`else
    localparam logic SIMD_EXP = 1'b0;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0, tmp, d0, seen;
        logic rv_seen;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_load = 1'b0; cmd_simd = 1'b0; cmd_len = '0;
        w_valid = 1'b0; w_data = '0; v_valid = 1'b0; v_data = '0;
        r_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_w_ready", w_ready, 1'b0);
        check("rst_v_ready", v_ready, 1'b0);
        check("rst_r_valid", r_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_load_ctrl", pe_load_ctrl, 8'h00);
        check("rst_pe_data", pe_data, 16'h0000);
        check("rst_simd", pe_simd_mode, 1'b0);
        check("rst_sum_in", pe_sum_in, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_credits", dbg_credits, 32'(FD));
        align();
        rst = 1'b0;

        // Weight preload followed by three streamed vectors.
        d0 = done_cnt;
        send_cmd(1'b1, 1'b0, 16'd3);
        for (int i = 0; i < 4; i++) send_weight(wts[i], wctl[i]);
        send_vec(vec_a[0], exp_a[0], acc0);
        for (int i = 1; i < 3; i++) send_vec(vec_a[i], exp_a[i], tmp);
        wait_idle();
        check("first_result_latency", rv_rise - acc0, NUM_PE + 2);
        check("load_done_count", done_cnt - d0, 1);
        check("load_queue_empty", ld_q.size(), 0);
        check("stream_results_drained", exp_q.size(), 0);

        // Backpressure: the credit limit must stop the stream at FIFO_DEPTH.
        r_ready = 1'b0;
        n_acc = 0;
        send_cmd(1'b0, 1'b0, 16'd10);
        fork
            begin
                for (int i = 0; i < 10; i++) send_vec(vec_b[i], exp_b[i], tmp);
            end
            begin
                repeat (20) @(negedge clk);
                check("bp_accepts", n_acc, FD);
                check("bp_v_ready", v_ready, 1'b0);
                check("bp_credits", dbg_credits, 0);
                align();
                r_ready = 1'b1;
            end
        join
        wait_idle();
        check("bp_all_accepted", n_acc, 10);
        check("bp_results_drained", exp_q.size(), 0);

        // Zero-length command with no preload.
        d0 = done_cnt;
        seen = -1;
        rv_seen = 1'b0;
        send_cmd(1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done && seen < 0) seen = i;
            if (r_valid) rv_seen = 1'b1;
        end
        align();
        check("zero_len_done_in_time", (seen >= 0 && seen <= 1), 1'b1);
        check("zero_len_done_count", done_cnt - d0, 1);
        check("zero_len_no_result", rv_seen, 1'b0);

        // SIMD mode held for the whole command.
        send_cmd(1'b0, 1'b1, 16'd2);
        @(negedge clk);
        check("simd_after_cmd", pe_simd_mode, SIMD_EXP);
        align();
        send_vec(vec_s[0], exp_s[0], tmp);
        send_vec(vec_s[1], exp_s[1], tmp);
        @(negedge clk);
        check("simd_busy", busy, 1'b1);
        check("simd_in_drain", pe_simd_mode, SIMD_EXP);
        align();
        wait_idle();
        check("simd_results_drained", exp_q.size(), 0);

        // Reset in the middle of a stream: abort, discard in-flight results, no done.
        d0 = done_cnt;
        send_cmd(1'b0, 1'b0, 16'd5);
        send_vec(16'd7, 32'd22, tmp);
        send_vec(16'd8, 32'd25, tmp);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_no_done", done, 1'b0);
        align();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_r_valid", r_valid, 1'b0);
        check("mid_rst_credits", dbg_credits, 32'(FD));
        check("mid_rst_busy", busy, 1'b0);
        rv_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (r_valid) rv_seen = 1'b1;
        end
        check("mid_rst_no_late_result", rv_seen, 1'b0);
        check("mid_rst_done_count", done_cnt - d0, 0);
        check("idle_pe_data", pe_data, 16'h0000);
        check("idle_load_ctrl", pe_load_ctrl, 8'h00);
        check("idle_credits", dbg_credits, 32'(FD));
        align();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
